cpu_io_ctrl: RTL and testbench
==============================

Name: cpu_io_ctrl

Overview:
- Buffered I/O controller between the CPU's IN/OUT handshake ports and external peripheral streams.
- Input side: a peripheral pushes 16-bit words into an RX FIFO. The controller answers CPU `inp_req` with `inp_ack` plus data.
- Output side: CPU `out_req` words are captured into a TX FIFO, acknowledged with `out_ack`, and drained to the peripheral over valid/ready.
- Decouples CPU instruction timing from peripheral timing.

Parameters:
- DW, 16, data width of all data ports and FIFO entries.
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of occupancy counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- inp_req  input  1  CPU requests an input word; held high until `inp_ack`.
- inp_ack  output  1  one-cycle pulse; `inp_data` valid in the same cycle.
- inp_data  output  DW  word delivered to CPU.
- out_req  input  1  CPU requests an output; `out_data` is stable while high.
- out_data  input  DW  word from CPU.
- out_ack  output  1  one-cycle pulse; word has been captured.
- rx_valid  input  1  peripheral offers `rx_data`.
- rx_data  input  DW  peripheral input word.
- rx_ready  output  1  RX FIFO can accept a word.
- tx_valid  output  1  TX FIFO head is valid.
- tx_data  output  DW  TX FIFO head word.
- tx_ready  input  1  peripheral accepts `tx_data`.
- rx_count  output  CW  RX FIFO occupancy.
- tx_count  output  CW  TX FIFO occupancy.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low on `rst_b`. It clears both FIFOs (pointers and counts = 0), puts both FSMs in IDLE, and sets `inp_ack = 0`, `out_ack = 0`, `inp_data = 0`.
  - After reset: `rx_ready = 1`, `tx_valid = 0`.
  - Reset mid-handshake discards in-flight words. No ack is issued for a request pending at reset. A request still high after release is served normally.
- RX FIFO:
  - `rx_ready = (rx_count != DEPTH)`; push on `rx_valid & rx_ready`.
  - `rx_ready` depends on count only. A pop in the same cycle does not allow a push when full.
- TX FIFO:
  - `tx_valid = (tx_count != 0)`; `tx_data` is the head, combinational from storage.
  - Pop on `tx_valid & tx_ready`.
- Pointers and counts:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts update as +push −pop. A simultaneous push and pop leaves the count unchanged.
- IN FSM (IN_IDLE, IN_ACK, IN_DROP):
  - IN_IDLE: if `inp_req & (rx_count != 0)` at edge k, register `inp_data <=` RX head, pop RX, go to IN_ACK. `inp_ack = 1` during cycle k+1.
  - If `inp_req` is high but RX is empty, stay in IN_IDLE with `inp_ack` low (CPU stalls).
  - IN_ACK: go to IN_DROP unconditionally; `inp_ack` lasts exactly 1 cycle.
  - IN_DROP: wait for `inp_req == 0`, then go to IN_IDLE. This prevents a double pop on a lingering request.
  - `inp_data` holds its value until the next pop.
- OUT FSM (OUT_IDLE, OUT_ACK, OUT_DROP):
  - OUT_IDLE: if `out_req & (tx_count != DEPTH)` at edge k, push `out_data` into TX, go to OUT_ACK. `out_ack = 1` in cycle k+1.
  - If TX is full, wait with `out_ack` low.
  - OUT_ACK goes to OUT_DROP; OUT_DROP waits for `out_req == 0`, then goes to OUT_IDLE.
- Concurrency: both FSMs are independent and may ack in the same cycle.
  - An RX push by the peripheral and an RX pop by the IN FSM may occur in the same cycle.
  - A TX push by the OUT FSM and a TX pop by the peripheral may occur in the same cycle.
  - FIFO order is strictly preserved.
- Latency:
  - Peripheral word to CPU: minimum 2 edges (push at edge j, pop at edge j+1 if `inp_req` is high).
  - CPU word to peripheral: `tx_valid` high in the cycle after the capture edge.

Test Plan:
- Reset, then push rx 0x1234 and 0xBEEF; raise `inp_req` → `inp_ack` pulses 1 cycle with `inp_data = 0x1234`. Keep `inp_req` high 3 more cycles → no second ack. Drop and re-raise → ack with 0xBEEF, `rx_count = 0`.
- `inp_req` high with RX empty for 5 cycles → no ack. Push 0x00A5 → ack 2 cycles after the push edge, `inp_data = 0x00A5`.
- Hold `tx_ready = 0`; issue OUT of 0x0001..0x0004 (DEPTH = 4) → 4 acks, `tx_count = 4`. Fifth OUT 0x0005 → no ack. Set `tx_ready = 1` for 1 cycle → 0x0001 drains, 0x0005 is acked next, `tx_data` order 0x0002..0x0005.
- RX fill: `rx_valid` held with words 0x10..0x14 → `rx_ready` low after 4 pushes, `rx_count = 4`, 0x14 is held off. A CPU pop (0x10) raises `rx_ready` and 0x14 enters. Subsequent pops return 0x11, 0x12, 0x13, 0x14 (pointer wrap).
- Simultaneous: RX at count 2, push 0x77 and pop on the same edge → `rx_count` stays 2. `inp_ack` and `out_ack` are asserted in the same cycle with independent correct data.
- Assert `rst_b = 0` mid-OUT_ACK with `tx_count = 3` → immediately `out_ack = 0`, `tx_valid = 0`, counts 0, `inp_data = 0`. After release with `out_req` still high → a fresh capture and ack occur.

Source files
------------

// File: rtl/cpu_io_ctrl.sv
// Buffered CPU IN/OUT controller: RX FIFO feeds CPU input handshakes, TX FIFO
// captures CPU output words and drains them to the peripheral over valid/ready.
module cpu_io_ctrl #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          inp_req,
    output logic          inp_ack,
    output logic [DW-1:0] inp_data,
    input  logic          out_req,
    input  logic [DW-1:0] out_data,
    output logic          out_ack,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    output logic [CW-1:0] rx_count,
    output logic [CW-1:0] tx_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};

    localparam logic [1:0] IN_IDLE  = 2'd0;
    localparam logic [1:0] IN_ACK   = 2'd1;
    localparam logic [1:0] IN_DROP  = 2'd2;
    localparam logic [1:0] OUT_IDLE = 2'd0;
    localparam logic [1:0] OUT_ACK  = 2'd1;
    localparam logic [1:0] OUT_DROP = 2'd2;

    logic [DW-1:0] rx_mem_q [DEPTH];
    logic [DW-1:0] tx_mem_q [DEPTH];
    logic [PW-1:0] rx_wr_ptr_q, rx_rd_ptr_q, tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CW-1:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic [1:0]    in_state_q, in_state_d, out_state_q, out_state_d;
    logic [DW-1:0] inp_data_q;
    logic          rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;

    // Ready is a function of occupancy only, so a same-cycle pop never frees a full FIFO.
    assign rx_ready  = (rx_count_q != FULL_CNT);
    assign tx_valid  = (tx_count_q != ZERO_CNT);
    assign tx_data   = tx_mem_q[tx_rd_ptr_q];
    assign rx_count  = rx_count_q;
    assign tx_count  = tx_count_q;
    assign inp_ack   = (in_state_q == IN_ACK);
    assign out_ack   = (out_state_q == OUT_ACK);
    assign inp_data  = inp_data_q;

    assign rx_push_s = rx_valid & rx_ready;
    assign rx_pop_s  = (in_state_q == IN_IDLE) & inp_req & (rx_count_q != ZERO_CNT);
    assign tx_push_s = (out_state_q == OUT_IDLE) & out_req & (tx_count_q != FULL_CNT);
    assign tx_pop_s  = tx_valid & tx_ready;

    // Occupancy next-state for both FIFOs.
    always_comb begin
        rx_count_d = rx_count_q;
        tx_count_d = tx_count_q;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_d = rx_count_q + ONE_CNT;
            2'b01:   rx_count_d = rx_count_q - ONE_CNT;
            default: rx_count_d = rx_count_q;
        endcase
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + ONE_CNT;
            2'b01:   tx_count_d = tx_count_q - ONE_CNT;
            default: tx_count_d = tx_count_q;
        endcase
    end

    // IN and OUT handshake FSMs; the DROP states wait out a lingering request.
    always_comb begin
        in_state_d  = in_state_q;
        out_state_d = out_state_q;
        case (in_state_q)
            IN_IDLE: begin
                if (rx_pop_s) in_state_d = IN_ACK;
                else          in_state_d = IN_IDLE;
            end
            IN_ACK:  in_state_d = IN_DROP;
            IN_DROP: begin
                if (!inp_req) in_state_d = IN_IDLE;
                else          in_state_d = IN_DROP;
            end
            default: in_state_d = IN_IDLE;
        endcase
        case (out_state_q)
            OUT_IDLE: begin
                if (tx_push_s) out_state_d = OUT_ACK;
                else           out_state_d = OUT_IDLE;
            end
            OUT_ACK:  out_state_d = OUT_DROP;
            OUT_DROP: begin
                if (!out_req) out_state_d = OUT_IDLE;
                else          out_state_d = OUT_DROP;
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // Control registers: FSM states, pointers, counts and the delivered CPU word.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            rx_wr_ptr_q <= {PW{1'b0}};
            rx_rd_ptr_q <= {PW{1'b0}};
            tx_wr_ptr_q <= {PW{1'b0}};
            tx_rd_ptr_q <= {PW{1'b0}};
            rx_count_q  <= ZERO_CNT;
            tx_count_q  <= ZERO_CNT;
            inp_data_q  <= {DW{1'b0}};
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            rx_count_q  <= rx_count_d;
            tx_count_q  <= tx_count_d;
            if (rx_push_s) rx_wr_ptr_q <= rx_wr_ptr_q + ONE_PTR;
            if (tx_push_s) tx_wr_ptr_q <= tx_wr_ptr_q + ONE_PTR;
            if (tx_pop_s)  tx_rd_ptr_q <= tx_rd_ptr_q + ONE_PTR;
            if (rx_pop_s) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + ONE_PTR;
                inp_data_q  <= rx_mem_q[rx_rd_ptr_q];
            end
        end
    end

    // FIFO storage, cleared on reset so no stale word is ever observable.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_q[i] <= {DW{1'b0}};
                tx_mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            if (rx_push_s) rx_mem_q[rx_wr_ptr_q] <= rx_data;
            if (tx_push_s) tx_mem_q[tx_wr_ptr_q] <= out_data;
        end
    end

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Directed bench for cpu_io_ctrl: one task per scenario with inline checks.
module tb_cpu_io_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        inp_req, out_req, rx_valid, tx_ready;
    logic [15:0] out_data, rx_data;
    logic        inp_ack, out_ack, rx_ready, tx_valid;
    logic [15:0] inp_data, tx_data;
    logic [2:0]  rx_count, tx_count;
    int          errors = 0;
    int          checks = 0;

    cpu_io_ctrl #(.DW(16), .DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; inp_req = 1'b0; out_req = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        out_data = 16'h0000; rx_data = 16'h0000;
        step(); step();
        checks++; if (inp_ack !== 1'b0) begin errors++; $display("FAIL rst_inp_ack got %0h want 0", inp_ack); end
        checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL rst_out_ack got %0h want 0", out_ack); end
        checks++; if (inp_data !== 16'h0000) begin errors++; $display("FAIL rst_inp_data got %0h want 0", inp_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready got %0h want 1", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %0h want 0", tx_valid); end
        checks++; if (rx_count !== 3'd0 || tx_count !== 3'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", rx_count, tx_count); end
        rst_b = 1'b1;
        step();
    endtask

    task automatic test_inp_basic();
        rx_valid = 1'b1; rx_data = 16'h1234; step();
        rx_data = 16'hBEEF; step();
        rx_valid = 1'b0;
        checks++; if (rx_count !== 3'd2) begin errors++; $display("FAIL basic_rx_count got %0d want 2", rx_count); end
        inp_req = 1'b1; step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'h1234) begin errors++; $display("FAIL basic_ack1 got ack=%0h data=%0h want 1/1234", inp_ack, inp_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (inp_ack !== 1'b0 || rx_count !== 3'd1) begin errors++; $display("FAIL basic_no_double got ack=%0h cnt=%0d want 0/1", inp_ack, rx_count); end
        end
        inp_req = 1'b0; step();
        inp_req = 1'b1; step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'hBEEF || rx_count !== 3'd0) begin errors++; $display("FAIL basic_ack2 got ack=%0h data=%0h cnt=%0d want 1/beef/0", inp_ack, inp_data, rx_count); end
        inp_req = 1'b0; step(); step();
    endtask

    task automatic test_inp_stall();
        inp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (inp_ack !== 1'b0) begin errors++; $display("FAIL stall_no_ack got %0h want 0", inp_ack); end
        end
        rx_valid = 1'b1; rx_data = 16'h00A5; step();
        rx_valid = 1'b0;
        checks++; if (inp_ack !== 1'b0) begin errors++; $display("FAIL stall_early_ack got %0h want 0", inp_ack); end
        step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'h00A5) begin errors++; $display("FAIL stall_ack got ack=%0h data=%0h want 1/00a5", inp_ack, inp_data); end
        inp_req = 1'b0; step(); step();
    endtask

    task automatic test_tx_fill();
        tx_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            out_data = 16'(v); out_req = 1'b1; step();
            checks++; if (out_ack !== 1'b1 || tx_count !== 3'(v)) begin errors++; $display("FAIL txfill_ack%0d got ack=%0h cnt=%0d want 1/%0d", v, out_ack, tx_count, v); end
            out_req = 1'b0; step(); step();
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 16'h0001) begin errors++; $display("FAIL txfill_head got v=%0h d=%0h want 1/0001", tx_valid, tx_data); end
        out_data = 16'h0005; out_req = 1'b1; step(); step();
        checks++; if (out_ack !== 1'b0 || tx_count !== 3'd4) begin errors++; $display("FAIL txfull_wait got ack=%0h cnt=%0d want 0/4", out_ack, tx_count); end
        tx_ready = 1'b1; step();
        tx_ready = 1'b0;
        checks++; if (out_ack !== 1'b0 || tx_count !== 3'd3 || tx_data !== 16'h0002) begin errors++; $display("FAIL txfull_drain got ack=%0h cnt=%0d d=%0h want 0/3/0002", out_ack, tx_count, tx_data); end
        step();
        checks++; if (out_ack !== 1'b1 || tx_count !== 3'd4) begin errors++; $display("FAIL txfull_late_ack got ack=%0h cnt=%0d want 1/4", out_ack, tx_count); end
        out_req = 1'b0; step(); step();
        tx_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 16'(v)) begin errors++; $display("FAIL tx_order got v=%0h d=%0h want 1/%0h", tx_valid, tx_data, v); end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0 || tx_count !== 3'd0) begin errors++; $display("FAIL tx_empty got v=%0h cnt=%0d want 0/0", tx_valid, tx_count); end
    endtask

    task automatic test_rx_fill();
        rx_valid = 1'b1;
        for (int v = 16; v <= 19; v++) begin
            rx_data = 16'(v); step();
        end
        rx_data = 16'h0014; step();
        checks++; if (rx_ready !== 1'b0 || rx_count !== 3'd4) begin errors++; $display("FAIL rxfull got rdy=%0h cnt=%0d want 0/4", rx_ready, rx_count); end
        inp_req = 1'b1; step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'h0010 || rx_count !== 3'd3 || rx_ready !== 1'b1) begin errors++; $display("FAIL rxfull_pop got ack=%0h d=%0h cnt=%0d rdy=%0h want 1/0010/3/1", inp_ack, inp_data, rx_count, rx_ready); end
        step();
        rx_valid = 1'b0;
        checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL rxfull_refill got cnt=%0d want 4", rx_count); end
        inp_req = 1'b0; step();
        for (int v = 17; v <= 20; v++) begin
            inp_req = 1'b1; step();
            checks++; if (inp_ack !== 1'b1 || inp_data !== 16'(v)) begin errors++; $display("FAIL rx_wrap got ack=%0h d=%0h want 1/%0h", inp_ack, inp_data, v); end
            inp_req = 1'b0; step(); step();
        end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL rx_wrap_empty got cnt=%0d want 0", rx_count); end
    endtask

    task automatic test_concurrent();
        rx_valid = 1'b1; rx_data = 16'h0020; step();
        rx_data = 16'h0021; step();
        rx_data = 16'h0077; inp_req = 1'b1; out_req = 1'b1; out_data = 16'h5A5A; step();
        rx_valid = 1'b0;
        checks++; if (rx_count !== 3'd2) begin errors++; $display("FAIL conc_rx_count got %0d want 2", rx_count); end
        checks++; if (inp_ack !== 1'b1 || out_ack !== 1'b1 || inp_data !== 16'h0020) begin errors++; $display("FAIL conc_acks got ia=%0h oa=%0h d=%0h want 1/1/0020", inp_ack, out_ack, inp_data); end
        checks++; if (tx_data !== 16'h5A5A || tx_count !== 3'd1) begin errors++; $display("FAIL conc_tx got d=%0h cnt=%0d want 5a5a/1", tx_data, tx_count); end
        inp_req = 1'b0; out_req = 1'b0; step(); step();
        inp_req = 1'b1; step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'h0021) begin errors++; $display("FAIL conc_next got ack=%0h d=%0h want 1/0021", inp_ack, inp_data); end
        inp_req = 1'b0; step(); step();
        inp_req = 1'b1; step();
        checks++; if (inp_ack !== 1'b1 || inp_data !== 16'h0077) begin errors++; $display("FAIL conc_last got ack=%0h d=%0h want 1/0077", inp_ack, inp_data); end
        inp_req = 1'b0; step(); step();
        tx_ready = 1'b1; step();
        tx_ready = 1'b0;
        checks++; if (tx_count !== 3'd0) begin errors++; $display("FAIL conc_tx_drain got cnt=%0d want 0", tx_count); end
    endtask

    task automatic test_reset_mid();
        for (int v = 1; v <= 2; v++) begin
            out_data = 16'(16'h0C00 + v); out_req = 1'b1; step();
            out_req = 1'b0; step(); step();
        end
        out_data = 16'h0C03; out_req = 1'b1; step();
        checks++; if (out_ack !== 1'b1 || tx_count !== 3'd3) begin errors++; $display("FAIL mid_pre got ack=%0h cnt=%0d want 1/3", out_ack, tx_count); end
        rst_b = 1'b0; out_data = 16'h0D04; #1;
        checks++; if (out_ack !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out got ack=%0h v=%0h want 0/0", out_ack, tx_valid); end
        checks++; if (tx_count !== 3'd0 || rx_count !== 3'd0 || inp_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_clr got tc=%0d rc=%0d d=%0h want 0/0/0", tx_count, rx_count, inp_data); end
        step();
        rst_b = 1'b1;
        checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL mid_release_ack got %0h want 0", out_ack); end
        step();
        checks++; if (out_ack !== 1'b1 || tx_count !== 3'd1 || tx_data !== 16'h0D04) begin errors++; $display("FAIL mid_recapture got ack=%0h cnt=%0d d=%0h want 1/1/0d04", out_ack, tx_count, tx_data); end
        out_req = 1'b0; step(); step();
    endtask

    initial begin
        test_reset();
        test_inp_basic();
        test_inp_stall();
        test_tx_fill();
        test_rx_fill();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
